// File: rtl/run_sequencer.sv
// Run sequencer for the single-cycle core: holds the core in reset on a start
// request, releases it, counts RUN cycles and ends the run on HALT or watchdog.
module run_sequencer #(
  parameter int            C         = 16,
  parameter int            CLR_CYC   = 2,
  parameter int            DRAIN_CYC = 1,
  parameter logic [C-1:0]  WDOG      = 16'd4000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         halt_seen,
  output logic         core_rst,
  output logic         core_en,
  output logic         done,
  output logic         timeout,
  output logic [C-1:0] cycle_cnt,
  output logic [2:0]   dbg_state
);

  localparam int PH_MAX = (CLR_CYC > DRAIN_CYC) ? CLR_CYC : DRAIN_CYC;
  localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PW-1:0] CLR_LAST   = PW'(CLR_CYC - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_next;
  logic [PW-1:0]   r_phase, w_phase_nxt;
  logic [C-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic            r_timeout, w_timeout_nxt;
  logic            r_req_q;
  logic            r_core_rst, r_core_en, r_done;
  logic            w_start;

  // Handshake: a run starts on the rising edge of req; the level is otherwise
  // ignored, and done stays asserted until the next rising edge.
  assign w_start   = req & ~r_req_q;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_next        = r_state;
    w_phase_nxt   = r_phase;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_next        = S_CLEAR;
          w_phase_nxt   = '0;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b0;
        end
      end
      S_CLEAR: begin
        if (r_phase == CLR_LAST) begin
          w_next      = S_RUN;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      S_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        // HALT takes priority over a coincident watchdog expiry.
        if (halt_seen) begin
          w_next      = S_DRAIN;
          w_phase_nxt = '0;
        end else if (w_cnt_inc == WDOG) begin
          w_next        = S_DONE;
          w_timeout_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_phase == DRAIN_LAST) begin
          w_next      = S_DONE;
          w_phase_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_req_q    <= 1'b0;
      r_core_rst <= 1'b1;
      r_core_en  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_phase    <= w_phase_nxt;
      r_cnt      <= w_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
      r_req_q    <= req;
      r_core_rst <= (w_next == S_IDLE) || (w_next == S_CLEAR);
      r_core_en  <= (w_next == S_RUN) || (w_next == S_DRAIN);
      r_done     <= (w_next == S_DONE);
    end
  end

  assign core_rst  = r_core_rst;
  assign core_en   = r_core_en;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign cycle_cnt = r_cnt;
  assign dbg_state = r_state;

endmodule
